// File: rtl/poly_pointwise_mul.sv
// Pointwise modular multiply of two N-coefficient polynomials streamed from RAMs.
// Three-stage pipeline: RAM data, 32-bit product, Barrett-reduced result write.
module poly_pointwise_mul #(
  parameter int N = 512,
  parameter int Q = 12289
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [8:0]  a_addr,
  input  logic [15:0] a_do,
  output logic [8:0]  b_addr,
  input  logic [15:0] b_do,
  output logic        r_we,
  output logic [8:0]  r_addr,
  output logic [15:0] r_di
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [8:0]  LAST_ADDR  = 9'(N - 1);
  localparam logic [1:0]  DRAIN_LAST = 2'd2;
  localparam logic [31:0] Q32        = 32'(Q);
  // floor(2^32 / Q): Barrett constant, folded at elaboration so no divider is built
  localparam logic [63:0] BARRETT_M  = (64'd1 << 32) / 64'(Q);

  logic [1:0]  state;
  logic [8:0]  cnt;
  logic [1:0]  drain_cnt;

  logic        d_valid;
  logic [8:0]  d_addr;
  logic        p_valid;
  logic [8:0]  p_addr;
  logic [31:0] prod;

  logic [31:0] q_est;
  logic [31:0] rem;
  logic [15:0] red;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          if (cnt == LAST_ADDR) begin
            state     <= S_DRAIN;
            cnt       <= '0;
            drain_cnt <= '0;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= S_DONE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign a_addr = (state == S_RUN) ? cnt : 9'd0;
  assign b_addr = (state == S_RUN) ? cnt : 9'd0;

  // q_est undershoots floor(x/Q) by at most one, so a single subtract gives the exact residue
  always_comb begin
    q_est = 32'(({32'd0, prod} * BARRETT_M) >> 32);
    rem   = prod - q_est * Q32;
    if (rem >= Q32) begin
      rem = rem - Q32;
    end
    red = 16'(rem);
  end

  // Address i enters in RUN cycle i, its data is on the RAM ports one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_addr  <= '0;
      p_valid <= 1'b0;
      p_addr  <= '0;
      prod    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_di    <= '0;
    end else begin
      d_valid <= (state == S_RUN);
      d_addr  <= (state == S_RUN) ? cnt : 9'd0;
      p_valid <= d_valid;
      p_addr  <= d_addr;
      prod    <= d_valid ? ({16'd0, a_do} * {16'd0, b_do}) : 32'd0;
      r_we    <= p_valid;
      r_addr  <= p_valid ? p_addr : 9'd0;
      r_di    <= p_valid ? red : 16'd0;
    end
  end

endmodule

// File: tb/tb_poly_pointwise_mul.sv
// Self-checking bench for poly_pointwise_mul: RAM models, per-cycle capture,
// and a timing/arithmetic reference model built from plain modular arithmetic.
module tb_poly_pointwise_mul;

  localparam int N      = 512;
  localparam int Q      = 12289;
  localparam int PERIOD = N + 5;
  localparam int MAXC   = 2200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, r_we;
  logic [8:0]  a_addr, b_addr, r_addr;
  logic [15:0] a_do = '0, b_do = '0, r_di;

  logic [15:0] a_mem [N];
  logic [15:0] b_mem [N];
  logic [15:0] exp_di [N];

  logic        obs_busy  [MAXC];
  logic        obs_done  [MAXC];
  logic        obs_we    [MAXC];
  logic [8:0]  obs_raddr [MAXC];
  logic [8:0]  obs_aaddr [MAXC];
  logic [8:0]  obs_baddr [MAXC];
  logic [15:0] obs_rdi   [MAXC];

  int n_checks = 0;
  int n_fail   = 0;

  poly_pointwise_mul #(.N(N), .Q(Q)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .a_addr (a_addr),
    .a_do   (a_do),
    .b_addr (b_addr),
    .b_do   (b_do),
    .r_we   (r_we),
    .r_addr (r_addr),
    .r_di   (r_di)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAMs: data appears the cycle after the address
  always @(posedge clk) begin
    a_do <= a_mem[a_addr];
    b_do <= b_mem[b_addr];
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: where cycle k falls relative to back-to-back passes started at k=0
  function automatic void expect_at(input int k, input int npasses,
                                    output logic e_busy, output logic e_done,
                                    output logic e_we, output logic [8:0] e_raddr,
                                    output logic [8:0] e_aaddr, output logic [15:0] e_rdi);
    int p;
    int pass_idx;
    p        = k % PERIOD;
    pass_idx = k / PERIOD;
    e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0;
    e_raddr = '0; e_aaddr = '0; e_rdi = '0;
    if (pass_idx < npasses) begin
      e_busy = (p <= N + 3);
      e_done = (p == N + 3);
      if (p < N) e_aaddr = 9'(p);
      if (p >= 3 && p <= N + 2) begin
        e_we    = 1'b1;
        e_raddr = 9'(p - 3);
        e_rdi   = exp_di[p - 3];
      end
    end
  endfunction

  // Called at a negedge with the DUT idle; start is held for 'hold' accepting edges
  task automatic capture_pass(input int ncyc, input int hold);
    start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if (k + 1 >= hold) start = 1'b0;
      @(negedge clk);
      obs_busy[k]  = busy;
      obs_done[k]  = done;
      obs_we[k]    = r_we;
      obs_raddr[k] = r_addr;
      obs_aaddr[k] = a_addr;
      obs_baddr[k] = b_addr;
      obs_rdi[k]   = r_di;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      a_mem[i]  = 16'($urandom);
      b_mem[i]  = 16'($urandom);
      exp_di[i] = 16'((longint'(a_mem[i]) * longint'(b_mem[i])) % Q);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, r_we, a_addr, b_addr, r_addr, r_di} !== 46'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got busy=%b done=%b we=%b a_addr=%0d b_addr=%0d r_addr=%0d r_di=%0d, expected all 0",
               busy, done, r_we, a_addr, b_addr, r_addr, r_di);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, r_we} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b we=%b, expected 0 0 0", busy, done, r_we);
    end
  endtask

  task automatic test_ramp();
    logic eb, ed, ew;
    logic [8:0] er, ea;
    logic [15:0] edi;
    for (int i = 0; i < N; i++) begin
      a_mem[i] = 16'(i); b_mem[i] = 16'd1; exp_di[i] = 16'(i);
    end
    capture_pass(PERIOD, 1);
    for (int k = 0; k < PERIOD; k++) begin
      expect_at(k, 1, eb, ed, ew, er, ea, edi);
      n_checks++;
      if ({obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], (ew ? obs_rdi[k] : 16'd0), obs_aaddr[k], obs_baddr[k]}
          !== {eb, ed, ew, er, edi, ea, ea}) begin
        n_fail++;
        $display("[TB] FAIL ramp c0+%0d: got busy=%b done=%b we=%b r_addr=%0d r_di=%0d a_addr=%0d b_addr=%0d, expected busy=%b done=%b we=%b r_addr=%0d r_di=%0d addr=%0d",
                 k, obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], obs_rdi[k], obs_aaddr[k], obs_baddr[k], eb, ed, ew, er, edi, ea);
      end
    end
  endtask

  task automatic test_max_residue();
    logic eb, ed, ew;
    logic [8:0] er, ea;
    logic [15:0] edi;
    // (Q-1)^2 = (-1)^2 = 1 mod Q
    for (int i = 0; i < N; i++) begin
      a_mem[i] = 16'd12288; b_mem[i] = 16'd12288; exp_di[i] = 16'd1;
    end
    capture_pass(PERIOD, 1);
    for (int k = 0; k < PERIOD; k++) begin
      expect_at(k, 1, eb, ed, ew, er, ea, edi);
      n_checks++;
      if ({obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], (ew ? obs_rdi[k] : 16'd0)} !== {eb, ed, ew, er, edi}) begin
        n_fail++;
        $display("[TB] FAIL max_residue c0+%0d: got busy=%b done=%b we=%b r_addr=%0d r_di=%0d, expected busy=%b done=%b we=%b r_addr=%0d r_di=%0d",
                 k, obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], obs_rdi[k], eb, ed, ew, er, edi);
      end
    end
  endtask

  task automatic test_unreduced();
    logic eb, ed, ew;
    logic [8:0] er, ea;
    logic [15:0] edi;
    // 65535 = 4090 mod Q and 4090^2 mod Q = 2771; Q*7 is 0 mod Q
    for (int i = 0; i < N; i++) begin
      if (i % 2 == 0) begin
        a_mem[i] = 16'hFFFF; b_mem[i] = 16'hFFFF; exp_di[i] = 16'd2771;
      end else begin
        a_mem[i] = 16'd12289; b_mem[i] = 16'd7; exp_di[i] = 16'd0;
      end
    end
    capture_pass(PERIOD, 1);
    for (int k = 0; k < PERIOD; k++) begin
      expect_at(k, 1, eb, ed, ew, er, ea, edi);
      n_checks++;
      if ({obs_we[k], obs_raddr[k], (ew ? obs_rdi[k] : 16'd0)} !== {ew, er, edi}) begin
        n_fail++;
        $display("[TB] FAIL unreduced c0+%0d: got we=%b r_addr=%0d r_di=%0d, expected we=%b r_addr=%0d r_di=%0d",
                 k, obs_we[k], obs_raddr[k], obs_rdi[k], ew, er, edi);
      end
    end
  endtask

  task automatic test_random();
    logic eb, ed, ew;
    logic [8:0] er, ea;
    logic [15:0] edi;
    int nwr;
    int last_addr;
    fill_random();
    capture_pass(PERIOD, 1);
    for (int k = 0; k < PERIOD; k++) begin
      expect_at(k, 1, eb, ed, ew, er, ea, edi);
      n_checks++;
      if ({obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], (ew ? obs_rdi[k] : 16'd0), obs_aaddr[k], obs_baddr[k]}
          !== {eb, ed, ew, er, edi, ea, ea}) begin
        n_fail++;
        $display("[TB] FAIL random c0+%0d: got busy=%b done=%b we=%b r_addr=%0d r_di=%0d a_addr=%0d b_addr=%0d, expected busy=%b done=%b we=%b r_addr=%0d r_di=%0d addr=%0d",
                 k, obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], obs_rdi[k], obs_aaddr[k], obs_baddr[k], eb, ed, ew, er, edi, ea);
      end
    end
    nwr = 0;
    last_addr = -1;
    for (int k = 0; k < PERIOD; k++) begin
      if (obs_we[k] === 1'b1) begin
        nwr++;
        n_checks++;
        if (int'(obs_raddr[k]) <= last_addr) begin
          n_fail++;
          $display("[TB] FAIL random_addr_order c0+%0d: got r_addr=%0d, required greater than %0d", k, obs_raddr[k], last_addr);
        end
        last_addr = int'(obs_raddr[k]);
      end
    end
    n_checks++;
    if (nwr != N) begin
      n_fail++;
      $display("[TB] FAIL random_write_count: got %0d writes, expected %0d", nwr, N);
    end
  endtask

  task automatic test_back_to_back();
    logic eb, ed, ew;
    logic [8:0] er, ea;
    logic [15:0] edi;
    int ncyc;
    // start held for 2000 cycles covers four passes of PERIOD cycles each
    ncyc = 4 * PERIOD;
    fill_random();
    capture_pass(ncyc, 2000);
    for (int k = 0; k < ncyc; k++) begin
      expect_at(k, 4, eb, ed, ew, er, ea, edi);
      n_checks++;
      if ({obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], (ew ? obs_rdi[k] : 16'd0), obs_aaddr[k]}
          !== {eb, ed, ew, er, edi, ea}) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cycle %0d: got busy=%b done=%b we=%b r_addr=%0d r_di=%0d a_addr=%0d, expected busy=%b done=%b we=%b r_addr=%0d r_di=%0d a_addr=%0d",
                 k, obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], obs_rdi[k], obs_aaddr[k], eb, ed, ew, er, edi, ea);
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    logic eb, ed, ew;
    logic [8:0] er, ea;
    logic [15:0] edi;
    fill_random();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    n_checks++;
    if ({busy, r_we, r_addr} !== {1'b1, 1'b1, 9'd97}) begin
      n_fail++;
      $display("[TB] FAIL pre_abort c0+100: got busy=%b we=%b r_addr=%0d, expected 1 1 97", busy, r_we, r_addr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, r_we, a_addr, b_addr, r_addr, r_di} !== 46'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_async: got busy=%b done=%b we=%b a_addr=%0d b_addr=%0d r_addr=%0d r_di=%0d, expected all 0",
               busy, done, r_we, a_addr, b_addr, r_addr, r_di);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, r_we} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL abort_quiet idle cycle %0d: got busy=%b done=%b we=%b, expected 0 0 0", k, busy, done, r_we);
      end
    end
    capture_pass(PERIOD, 1);
    for (int k = 0; k < PERIOD; k++) begin
      expect_at(k, 1, eb, ed, ew, er, ea, edi);
      n_checks++;
      if ({obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], (ew ? obs_rdi[k] : 16'd0), obs_aaddr[k]}
          !== {eb, ed, ew, er, edi, ea}) begin
        n_fail++;
        $display("[TB] FAIL after_abort c0+%0d: got busy=%b done=%b we=%b r_addr=%0d r_di=%0d a_addr=%0d, expected busy=%b done=%b we=%b r_addr=%0d r_di=%0d a_addr=%0d",
                 k, obs_busy[k], obs_done[k], obs_we[k], obs_raddr[k], obs_rdi[k], obs_aaddr[k], eb, ed, ew, er, edi, ea);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_mem[i] = '0; b_mem[i] = '0; exp_di[i] = '0;
    end
    test_reset();
    test_ramp();
    test_max_residue();
    test_unreduced();
    test_random();
    test_back_to_back();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
